// File: rtl/tdp_ram_be_sc.sv
// Single-clock true dual-port RAM with byte enables and selectable read-during-write behaviour.
// Includes an optional output register, read-valid strobes, collision flagging and a zero-fill engine.
module tdp_ram_be_sc #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 9,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_req,
  output logic                init_busy,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   wdata_a,
  output logic [DATA_W-1:0]   rdata_a,
  output logic                rvalid_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rvalid_b,
  output logic                collision
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc_a, acc_b, wr_a, wr_b, collision_d;
  logic [DATA_W-1:0]   merged_a, merged_b, rdata_a_d, rdata_b_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_b_q;
  logic                rvalid_a_q, rvalid_b_q, collision_q;

  assign init_busy   = (state_q == S_CLEAR);
  assign acc_a       = en_a & ~init_busy;
  assign acc_b       = en_b & ~init_busy;
  assign wr_a        = acc_a & we_a;
  assign wr_b        = acc_b & we_b;
  assign collision_d = acc_a & acc_b & (addr_a == addr_b) & (we_a | we_b);

  // Zero-fill engine: the pointer wraps to 0 on its last write, so it is ready for the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_ptr_q <= '0;
    end else begin
      // NOTE: sequential state is written with <= so every register samples pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
          end
        end
        S_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (&clr_ptr_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; clearing it is the job of the fill engine.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[clr_ptr_q] <= '0;
    end else begin
      // Port A is assigned last so its enabled bytes win a same-address conflict.
      for (int i = 0; i < BE_W; i++) begin
        if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
        if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    merged_a = mem[addr_a];
    merged_b = mem[addr_b];
    for (int i = 0; i < BE_W; i++) begin
      if (be_a[i]) merged_a[8*i +: 8] = wdata_a[8*i +: 8];
      if (be_b[i]) merged_b[8*i +: 8] = wdata_b[8*i +: 8];
    end
    rdata_a_d = ((RDW_MODE != 0) && we_a) ? merged_a : mem[addr_a];
    rdata_b_d = ((RDW_MODE != 0) && we_b) ? merged_b : mem[addr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      rvalid_a_q  <= acc_a;
      rvalid_b_q  <= acc_b;
      collision_q <= collision_d;
      if (acc_a) rdata_a_q <= rdata_a_d;
      if (acc_b) rdata_b_q <= rdata_b_d;
    end
  end

  assign collision = collision_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] rdata_a_q2, rdata_b_q2;
    logic              rvalid_a_q2, rvalid_b_q2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_a_q2  <= '0;
        rdata_b_q2  <= '0;
        rvalid_a_q2 <= 1'b0;
        rvalid_b_q2 <= 1'b0;
      end else begin
        rvalid_a_q2 <= rvalid_a_q;
        rvalid_b_q2 <= rvalid_b_q;
        if (rvalid_a_q) rdata_a_q2 <= rdata_a_q;
        if (rvalid_b_q) rdata_b_q2 <= rdata_b_q;
      end
    end

    assign rdata_a  = rdata_a_q2;
    assign rdata_b  = rdata_b_q2;
    assign rvalid_a = rvalid_a_q2;
    assign rvalid_b = rvalid_b_q2;
  end else begin : g_no_out_reg
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
  end

endmodule

// File: tb/tb_tdp_ram_be_sc.sv
// Self-checking bench for tdp_ram_be_sc: directed vector table, corner-case sequences and
// randomized traffic compared against an array-based reference model of the RAM contract.
module tb_tdp_ram_be_sc;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int RDW_MODE = 0;
  localparam int OUT_REG  = 0;
  localparam int LAT      = (OUT_REG != 0) ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        init_busy;
  logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [3:0]  be_a = '0, be_b = '0, addr_a = '0, addr_b = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, collision;

  always #5 clk = ~clk;

  tdp_ram_be_sc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE),
    .OUT_REG(OUT_REG), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(init_busy),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .collision(collision)
  );

  typedef struct {
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic [31:0] db;
  } rd_t;

  typedef struct {
    logic        en_a, we_a;
    logic [3:0]  be_a, addr_a;
    logic [31:0] wd_a;
    logic        en_b, we_b;
    logic [3:0]  be_b, addr_b;
    logic [31:0] wd_b;
    logic        xva;
    logic [31:0] xda;
    logic        xvb;
    logic [31:0] xdb;
    logic        xcoll;
  } vec_t;

  logic [31:0] model_mem [DEPTH];
  int          clr_left;
  rd_t         hist [$];
  logic        exp_va, exp_vb, exp_coll;
  logic [31:0] exp_da, exp_db;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; wdata_a = '0;
    en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; wdata_b = '0;
    clear_req = 1'b0;
  endtask

  // Advance one clock with the currently driven inputs, update the model and compare all outputs.
  task automatic tick();
    rd_t  nx;
    logic busy_now, coll_now;
    busy_now = (clr_left != 0);
    nx.va = en_a && !busy_now;
    nx.vb = en_b && !busy_now;
    nx.da = ((RDW_MODE != 0) && we_a) ? merge(model_mem[addr_a], wdata_a, be_a) : model_mem[addr_a];
    nx.db = ((RDW_MODE != 0) && we_b) ? merge(model_mem[addr_b], wdata_b, be_b) : model_mem[addr_b];
    coll_now = nx.va && nx.vb && (addr_a == addr_b) && (we_a || we_b);
    if (busy_now) begin
      model_mem[DEPTH - clr_left] = '0;
      clr_left--;
    end else begin
      if (nx.vb && we_b) model_mem[addr_b] = merge(model_mem[addr_b], wdata_b, be_b);
      if (nx.va && we_a) model_mem[addr_a] = merge(model_mem[addr_a], wdata_a, be_a);
      if (clear_req) clr_left = DEPTH;
    end
    hist.push_back(nx);
    if (hist.size() > LAT) void'(hist.pop_front());
    if (hist.size() == LAT) begin
      exp_va = hist[0].va;
      exp_vb = hist[0].vb;
      if (hist[0].va) exp_da = hist[0].da;
      if (hist[0].vb) exp_db = hist[0].db;
    end else begin
      exp_va = 1'b0;
      exp_vb = 1'b0;
    end
    exp_coll = coll_now;
    @(posedge clk);
    @(negedge clk);
    check("init_busy", 32'(init_busy), 32'(clr_left != 0));
    check("rvalid_a", 32'(rvalid_a), 32'(exp_va));
    check("rvalid_b", 32'(rvalid_b), 32'(exp_vb));
    check("rdata_a", rdata_a, exp_da);
    check("rdata_b", rdata_b, exp_db);
    check("collision", 32'(collision), 32'(exp_coll));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rdata_a"}, rdata_a, 32'h0);
    check({tag, " rdata_b"}, rdata_b, 32'h0);
    check({tag, " rvalid_a"}, 32'(rvalid_a), 32'h0);
    check({tag, " rvalid_b"}, 32'(rvalid_b), 32'h0);
    check({tag, " collision"}, 32'(collision), 32'h0);
    check({tag, " init_busy"}, 32'(init_busy), 32'h1);
  endtask

  // Called on a falling edge; returns on a falling edge with rst_n released.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    hist.delete();
    exp_va = 1'b0; exp_vb = 1'b0; exp_da = '0; exp_db = '0; exp_coll = 1'b0;
    clr_left = 0;
    check_reset_outputs("reset_entry");
    repeat (hold) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    clr_left = DEPTH;
  endtask

  // Count cycles of init_busy after a clear starts, optionally poking port A mid-fill.
  task automatic count_busy(input string tag, input logic poke);
    int busy_cycles;
    busy_cycles = 0;
    while (init_busy && busy_cycles < 100) begin
      en_a    = poke && (busy_cycles == 3);
      we_a    = en_a;
      be_a    = 4'hF;
      addr_a  = 4'd15;
      wdata_a = 32'hFFFF_FFFF;
      tick();
      busy_cycles++;
    end
    idle();
    check(tag, busy_cycles, 16);
  endtask

  function automatic vec_t mk(input logic ea, input logic wa, input logic [3:0] ba,
                              input logic [3:0] aa, input logic [31:0] da,
                              input logic eb, input logic wb, input logic [3:0] bb,
                              input logic [3:0] ab, input logic [31:0] db,
                              input logic xva, input logic [31:0] xda,
                              input logic xvb, input logic [31:0] xdb, input logic xc);
    vec_t v;
    v.en_a = ea; v.we_a = wa; v.be_a = ba; v.addr_a = aa; v.wd_a = da;
    v.en_b = eb; v.we_b = wb; v.be_b = bb; v.addr_b = ab; v.wd_b = db;
    v.xva = xva; v.xda = xda; v.xvb = xvb; v.xdb = xdb; v.xcoll = xc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int   cnt_a, cnt_b;
    logic rdw;
    rdw = (RDW_MODE != 0);

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hxxxx_xxxx;
    idle();
    @(negedge clk);

    // Power-up fill, with a write attempt on port A that must be ignored.
    do_reset(2);
    count_busy("busy_len_powerup", 1'b1);

    // Both ports stream all addresses back-to-back; every word must read zero.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < DEPTH + LAT; i++) begin
      en_a = (i < DEPTH); addr_a = 4'(i);
      en_b = (i < DEPTH); addr_b = 4'(i);
      tick();
      if (rvalid_a) cnt_a++;
      if (rvalid_b) cnt_b++;
    end
    idle();
    check("stream_count_a", cnt_a, 16);
    check("stream_count_b", cnt_b, 16);

    vecs[0] = mk(1, 1, 4'hF, 3, 32'hAABBCCDD, 0, 0, 0, 0, 0,
                 1, rdw ? 32'hAABBCCDD : 32'h0, 0, 0, 0);
    vecs[1] = mk(1, 1, 4'h5, 3, 32'h11223344, 0, 0, 0, 0, 0,
                 1, rdw ? 32'hAA22CC44 : 32'hAABBCCDD, 0, 0, 0);
    vecs[2] = mk(0, 0, 0, 0, 0, 1, 0, 0, 3, 0,
                 0, 0, 1, 32'hAA22CC44, 0);
    vecs[3] = mk(1, 1, 4'hF, 5, 32'hDEADBEEF, 1, 0, 0, 5, 0,
                 1, rdw ? 32'hDEADBEEF : 32'h0, 1, 32'h0, 1);
    vecs[4] = mk(1, 1, 4'h3, 7, 32'h11111111, 1, 1, 4'hF, 7, 32'h22222222,
                 1, rdw ? 32'h00001111 : 32'h0, 1, rdw ? 32'h22222222 : 32'h0, 1);
    vecs[5] = mk(1, 0, 0, 7, 0, 1, 0, 0, 5, 0,
                 1, 32'h22221111, 1, 32'hDEADBEEF, 0);
    vecs[6] = mk(1, 0, 0, 5, 0, 1, 0, 0, 5, 0,
                 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
    vecs[7] = mk(1, 1, 4'h0, 9, 32'hFFFFFFFF, 0, 0, 0, 0, 0,
                 1, 32'h0, 0, 0, 0);
    vecs[8] = mk(0, 0, 0, 0, 0, 1, 0, 0, 9, 0,
                 0, 0, 1, 32'h0, 0);

    foreach (vecs[k]) begin
      en_a = vecs[k].en_a; we_a = vecs[k].we_a; be_a = vecs[k].be_a;
      addr_a = vecs[k].addr_a; wdata_a = vecs[k].wd_a;
      en_b = vecs[k].en_b; we_b = vecs[k].we_b; be_b = vecs[k].be_b;
      addr_b = vecs[k].addr_b; wdata_b = vecs[k].wd_b;
      tick();
      check($sformatf("vec%0d collision", k), 32'(collision), 32'(vecs[k].xcoll));
      idle();
      for (int j = 1; j < LAT; j++) tick();
      check($sformatf("vec%0d rvalid_a", k), 32'(rvalid_a), 32'(vecs[k].xva));
      check($sformatf("vec%0d rvalid_b", k), 32'(rvalid_b), 32'(vecs[k].xvb));
      if (vecs[k].xva) check($sformatf("vec%0d rdata_a", k), rdata_a, vecs[k].xda);
      if (vecs[k].xvb) check($sformatf("vec%0d rdata_b", k), rdata_b, vecs[k].xdb);
      tick();
      check($sformatf("vec%0d collision_gone", k), 32'(collision), 32'h0);
    end

    // Clear request aborted by reset at fill cycle 8, then a full refill on release.
    en_a = 1; we_a = 1; be_a = 4'hF; addr_a = 15; wdata_a = 32'h5A5A5A5A;
    tick();
    we_a = 0;
    tick();
    idle();
    repeat (LAT) tick();
    check("addr15_before_clear", rdata_a, 32'h5A5A5A5A);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clear_req_busy", 32'(init_busy), 32'h1);
    repeat (8) tick();
    do_reset(3);
    count_busy("busy_len_reclear", 1'b0);
    en_a = 1; addr_a = 15;
    tick();
    idle();
    repeat (LAT - 1) tick();
    check("addr15_after_reclear", rdata_a, 32'h0);

    // Randomized dual-port traffic, biased towards low addresses to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      en_a = ($urandom_range(0, 3) != 0); we_a = 1'($urandom);
      be_a = 4'($urandom); wdata_a = $urandom;
      addr_a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      en_b = ($urandom_range(0, 3) != 0); we_b = 1'($urandom);
      be_b = 4'($urandom); wdata_b = $urandom;
      addr_b = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      clear_req = ($urandom_range(0, 149) == 0);
      tick();
    end
    idle();
    repeat (DEPTH + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdp_ram_be_sc.md
Name: tdp_ram_be_sc

Overview:
- Parametrised single-clock true dual-port RAM for the SDRAM controller datapath: buffering, reorder and scratch storage.
- Generalises the fixed 512x8 dual-port array:
  - configurable width and depth;
  - per-byte write enables;
  - selectable read-during-write mode;
  - optional output pipeline register;
  - read-valid strobes;
  - address collision detection;
  - hardware zero-fill state machine that runs after reset or on request.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of 8.
- ADDR_W, 9: address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0: same-port read-during-write. 0 = old data (read-first); 1 = new merged data (write-first).
- OUT_REG, 0: 1 adds an output pipeline stage (read latency 2 instead of 1).
- CLEAR_ON_RESET, 1: 1 = zero-fill the whole array after reset deassertion.

Ports:
- clk  in  1  single clock for both ports
- rst_n  in  1  asynchronous, active-low reset
- clear_req  in  1  pulse; starts a zero-fill when idle
- init_busy  out  1  high while zero-fill is pending or running
- en_a  in  1  port A access strobe
- we_a  in  1  port A write (qualified by en_a)
- be_a  in  DATA_W/8  port A byte enables
- addr_a  in  ADDR_W  port A address
- wdata_a  in  DATA_W  port A write data
- rdata_a  out  DATA_W  port A read data
- rvalid_a  out  1  rdata_a valid strobe
- en_b, we_b, be_b, addr_b, wdata_b, rdata_b, rvalid_b: same as port A, for port B
- collision  out  1  one-cycle pulse: same-address conflict detected

Behaviour:
- Reset (rst_n low, asynchronous):
  - rdata_a/b = 0, rvalid_a/b = 0, collision = 0, output pipeline registers = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET = 1, else IDLE.
  - init_busy = CLEAR_ON_RESET.
  - Memory contents are not reset asynchronously.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req = 1. clear_req is ignored while in CLEAR.
  - In CLEAR: writes all-zero to clr_ptr, one word per cycle. clr_ptr starts at 0 on entry.
  - CLEAR -> IDLE on the cycle that writes DEPTH-1.
  - A full clear takes exactly DEPTH cycles after rst_n rises or after the clear_req cycle.
  - init_busy is combinationally equal to (state == CLEAR).
  - rst_n asserted mid-clear aborts the fill. The fill restarts from 0 on release if CLEAR_ON_RESET = 1; otherwise the FSM stays in IDLE.
- While init_busy = 1:
  - en_a/en_b are ignored: no writes, rvalid stays 0, collision stays 0.
  - Outputs already in the pipeline still complete.
- Access rules:
  - Write when en and we: each byte i is written only where be[i] = 1. be = 0 leaves the word unchanged.
  - Read when en and !we.
  - A write access also produces a read with rvalid, returning data per RDW_MODE.
- Latency and hold:
  - rdata/rvalid appear 1 cycle after the access (OUT_REG = 0) or 2 cycles after (OUT_REG = 1).
  - rvalid is a single-cycle pulse per access.
  - rdata holds its last value when no access occurs.
- Cross-port same-address cases (en_a & en_b & addr_a == addr_b, at least one writing):
  - The reading side always gets the pre-write (old) data.
  - Both ports writing: per byte, port A wins where be_a[i] = 1. Port B's byte is written only where be_a[i] = 0 and be_b[i] = 1.
  - collision pulses high 1 cycle after the conflicting access, independent of OUT_REG.
  - Same-address reads on both ports are not a collision.
- Back-to-back accesses are supported every cycle on both ports. There is no stall and no backpressure.

Test Plan:
- Bench config: DATA_W = 32, ADDR_W = 4, CLEAR_ON_RESET = 1.
  - Release rst_n -> init_busy = 1 for exactly 16 cycles.
  - Read of every address 0..15 -> 0x00000000.
  - en_a pulsed during busy -> no rvalid_a.
- Byte enables:
  - Port A writes 0xAABBCCDD to addr 3 with be = 4'b1111.
  - Then writes 0x11223344 to addr 3 with be = 4'b0101.
  - Port B reads addr 3 -> 0xAA22CC44, rvalid_b 1 cycle later (OUT_REG = 0) or 2 cycles later (OUT_REG = 1).
- Read-during-write:
  - addr 5 holds 0x0; port A writes 0xDEADBEEF, full be.
  - rdata_a = 0x0 (RDW_MODE = 0) or 0xDEADBEEF (RDW_MODE = 1).
  - Port B reads addr 5 in the same cycle -> 0x0, collision = 1.
- Dual write collision:
  - A writes 0x11111111 with be_a = 4'b0011; B writes 0x22222222 with be_b = 4'b1111; both to addr 7, same cycle.
  - collision pulses once; later read of addr 7 -> 0x22221111.
- Mid-clear reset and re-clear:
  - clear_req after writing 0x5A5A5A5A to addr 15; assert rst_n at clear cycle 8.
  - On release: full 16-cycle clear, addr 15 reads 0x0.
  - All outputs read 0 while rst_n is low.
- Throughput:
  - Both ports read 16 consecutive addresses every cycle.
  - 16 rvalid pulses per port, in order, with correct data and no gaps.
